// File: rtl/seg7_pkg.sv
// ============================================================================
// Module      : seg7_pkg
// Description : Seven-segment pattern table and anode helpers, shared by the
//               display-driver and scan-reader sides of the display path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int SEG_W      = 7;
    localparam int DIG_IDX_W  = $clog2(NUM_DIGITS);

    // Active-low segments, bit6..bit0 = g,f,e,d,c,b,a
    localparam logic [SEG_W-1:0] SEG7_BLANK = 7'b1111111;

    localparam logic [SEG_W-1:0] SEG7_HEX [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef enum logic [1:0] {
        AN_IDLE   = 2'd0,
        AN_SINGLE = 2'd1,
        AN_MULTI  = 2'd2
    } an_class_e;

    // Anodes are active-low: no low bit is a blanking interval
    function automatic an_class_e an_classify(input logic [NUM_DIGITS-1:0] an);
        int lows;
        lows = 0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (!an[k]) begin
                lows = lows + 1;
            end
        end
        if (lows == 0) begin
            return AN_IDLE;
        end else if (lows == 1) begin
            return AN_SINGLE;
        end
        return AN_MULTI;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_to_hex.sv
// ============================================================================
// Module      : seg7_to_hex
// Description : Combinational inverse of the seven-segment hex encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] seg_i,
    output logic [3:0]       nibble_o,
    output logic             is_hex_o,
    output logic             is_blank_o
);

    always_comb begin
        nibble_o = 4'h0;
        is_hex_o = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg_i == SEG7_HEX[i]) begin
                nibble_o = 4'(i);
                is_hex_o = 1'b1;
            end
        end
    end

    assign is_blank_o = (seg_i == SEG7_BLANK);

endmodule

`default_nettype wire

// File: rtl/seg7_scan_reader.sv
// ============================================================================
// Module      : seg7_scan_reader
// Description : Samples a scanned 4-digit seven-segment bus and rebuilds the
//               displayed 16-bit value with blank, error and stale flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int SYNC_STAGES    = 2
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_DIGITS-1:0]     an_i,
    input  logic [SEG_W-1:0]          seg_i,
    output logic [4*NUM_DIGITS-1:0]   value_o,
    output logic [NUM_DIGITS-1:0]     blank_o,
    output logic                      valid_o,
    output logic                      err_o,
    output logic                      stale_o
);

    localparam int SAMPLE_W = NUM_DIGITS + SEG_W;
    localparam int CNT_W    = $clog2(STABLE_CYCLES);
    localparam int IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]      CNT_FIRE = CNT_W'(STABLE_CYCLES - 2);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [IDLE_W-1:0]     IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);
    localparam logic [IDLE_W-1:0]     IDLE_ONE = IDLE_W'(1);
    localparam logic [NUM_DIGITS-1:0] ALL_SEEN = '1;

    logic [SYNC_STAGES-1:0][SAMPLE_W-1:0] sync_q;
    logic [SAMPLE_W-1:0]                  prev_q;
    logic [CNT_W-1:0]                     cnt_q, cnt_d;
    logic [IDLE_W-1:0]                    idle_q, idle_d;

    logic [NUM_DIGITS-1:0][3:0]           dig_q, dig_d;
    logic [NUM_DIGITS-1:0]                blk_q, blk_d;
    logic [NUM_DIGITS-1:0]                bad_q, bad_d;
    logic [NUM_DIGITS-1:0]                seen_q, seen_d;
    logic                                 multi_q, multi_d;

    logic [4*NUM_DIGITS-1:0]              value_q;
    logic [NUM_DIGITS-1:0]                blank_q;
    logic                                 valid_q, err_q, stale_q;

    logic [SAMPLE_W-1:0]                  s_w;
    logic [NUM_DIGITS-1:0]                an_w;
    logic [SEG_W-1:0]                     seg_w;
    logic                                 same_w, capture_w, timeout_w, done_w;
    an_class_e                            class_w;
    logic [DIG_IDX_W-1:0]                 idx_w;
    logic [3:0]                           nib_w;
    logic                                 is_hex_w, is_blank_w;

    // ------------------------------------------------------------------
    // Input synchroniser and stability filter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], {an_i, seg_i}};
            prev_q <= s_w;
            cnt_q  <= cnt_d;
        end
    end

    assign s_w    = sync_q[SYNC_STAGES-1];
    assign an_w   = s_w[SAMPLE_W-1:SEG_W];
    assign seg_w  = s_w[SEG_W-1:0];
    assign same_w = (s_w == prev_q);

    always_comb begin
        cnt_d = '0;
        if (same_w) begin
            cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
        end
    end

    // Fires only on the transition into saturation: once per stable window
    assign capture_w = same_w && (cnt_q == CNT_FIRE);

    // ------------------------------------------------------------------
    // Digit decode and classification
    // ------------------------------------------------------------------
    seg7_to_hex u_dec (
        .seg_i      (seg_w),
        .nibble_o   (nib_w),
        .is_hex_o   (is_hex_w),
        .is_blank_o (is_blank_w)
    );

    assign class_w = an_classify(an_w);

    always_comb begin
        idx_w = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (!an_w[k]) begin
                idx_w = DIG_IDX_W'(k);
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame assembly and idle timeout
    // ------------------------------------------------------------------
    assign timeout_w = (idle_q == IDLE_MAX);

    always_comb begin
        dig_d   = dig_q;
        blk_d   = blk_q;
        bad_d   = bad_q;
        seen_d  = seen_q;
        multi_d = multi_q;
        idle_d  = (idle_q == IDLE_MAX) ? IDLE_MAX : idle_q + IDLE_ONE;

        // A real capture outranks a timeout landing in the same cycle
        if (capture_w && (class_w != AN_IDLE)) begin
            idle_d = '0;
            if (class_w == AN_SINGLE) begin
                dig_d[idx_w]  = is_hex_w ? nib_w : 4'h0;
                blk_d[idx_w]  = !is_hex_w && is_blank_w;
                bad_d[idx_w]  = !is_hex_w && !is_blank_w;
                seen_d[idx_w] = 1'b1;
            end else begin
                multi_d = 1'b1;
            end
        end else if (timeout_w) begin
            seen_d  = '0;
            bad_d   = '0;
            multi_d = 1'b0;
            idle_d  = '0;
        end
    end

    assign done_w = (seen_d == ALL_SEEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_q   <= '0;
            blk_q   <= '0;
            bad_q   <= '0;
            seen_q  <= '0;
            multi_q <= 1'b0;
            idle_q  <= '0;
        end else begin
            dig_q   <= dig_d;
            blk_q   <= blk_d;
            bad_q   <= done_w ? '0 : bad_d;
            seen_q  <= done_w ? '0 : seen_d;
            multi_q <= done_w ? 1'b0 : multi_d;
            idle_q  <= idle_d;
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
            blank_q <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            stale_q <= 1'b1;
        end else begin
            valid_q <= done_w;
            if (done_w) begin
                value_q <= dig_d;
                blank_q <= blk_d;
                err_q   <= (|bad_d) || multi_d;
                stale_q <= 1'b0;
            end else if (timeout_w && !(capture_w && (class_w != AN_IDLE))) begin
                stale_q <= 1'b1;
            end
        end
    end

    assign value_o = value_q;
    assign blank_o = blank_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;
    assign stale_o = stale_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_reader.sv
// ============================================================================
// Module      : tb_seg7_scan_reader
// Description : Directed self-checking bench for seg7_scan_reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_reader;

    localparam logic [6:0] P0 = 7'b1000000, P1 = 7'b1111001, P2 = 7'b0100100;
    localparam logic [6:0] P3 = 7'b0110000, P4 = 7'b0011001, P5 = 7'b0010010;
    localparam logic [6:0] P6 = 7'b0000010, P7 = 7'b1111000, P8 = 7'b0000000;
    localparam logic [6:0] P9 = 7'b0010000, PA = 7'b0001000, PB = 7'b0000011;
    localparam logic [6:0] PC = 7'b1000110, PD = 7'b0100001, PE = 7'b0000110;
    localparam logic [6:0] PF = 7'b0001110, PBL = 7'b1111111, PBAD = 7'b1010101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  an_i = 4'hF;
    logic [6:0]  seg_i = 7'h7F;
    logic [15:0] value_o;
    logic [3:0]  blank_o;
    logic        valid_o, err_o, stale_o;

    int errors = 0;
    int checks = 0;
    int vcount = 0;
    int v0;

    seg7_scan_reader #(
        .STABLE_CYCLES  (4),
        .TIMEOUT_CYCLES (50),
        .SYNC_STAGES    (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .an_i    (an_i),
        .seg_i   (seg_i),
        .value_o (value_o),
        .blank_o (blank_o),
        .valid_o (valid_o),
        .err_o   (err_o),
        .stale_o (stale_o)
    );

    always #5 clk = ~clk;

    // A pulse stuck high would be counted on every falling edge
    always @(negedge clk) begin
        if (valid_o === 1'b1) vcount++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
        an_i  = an;
        seg_i = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        hold(4'b1111, PBL, n);
    endtask

    task automatic scan4(input logic [6:0] p0, input logic [6:0] p1,
                         input logic [6:0] p2, input logic [6:0] p3, input int n);
        hold(4'b1110, p0, n);
        hold(4'b1101, p1, n);
        hold(4'b1011, p2, n);
        hold(4'b0111, p3, n);
        idle(8);
    endtask

    initial begin
        idle(3);
        chk("rst_value", 32'(value_o), 32'h0);
        chk("rst_blank", 32'(blank_o), 32'h0);
        chk("rst_valid", 32'(valid_o), 32'h0);
        chk("rst_err",   32'(err_o),   32'h0);
        chk("rst_stale", 32'(stale_o), 32'h1);
        rst_n = 1'b1;
        idle(5);
        chk("post_rst_valid_cnt", 32'(vcount), 32'h0);

        // 0x1A3F, 8-cycle holds
        v0 = vcount;
        scan4(PF, P3, PA, P1, 8);
        chk("t1_valid_cnt", 32'(vcount - v0), 32'd1);
        chk("t1_value", 32'(value_o), 32'h1A3F);
        chk("t1_blank", 32'(blank_o), 32'h0);
        chk("t1_err",   32'(err_o),   32'h0);
        chk("t1_stale", 32'(stale_o), 32'h0);

        // Leading blanks -> 0x0042, blank 1100
        v0 = vcount;
        scan4(P2, P4, PBL, PBL, 8);
        chk("t2_valid_cnt", 32'(vcount - v0), 32'd1);
        chk("t2_value", 32'(value_o), 32'h0042);
        chk("t2_blank", 32'(blank_o), 32'hC);
        chk("t2_err",   32'(err_o),   32'h0);

        // Glitch: digit 2 held only 2 cycles must not complete a frame
        v0 = vcount;
        hold(4'b1110, P8, 4);
        hold(4'b1101, P7, 4);
        hold(4'b1011, P6, 2);
        hold(4'b0111, P5, 4);
        idle(10);
        chk("t3_glitch_no_valid", 32'(vcount - v0), 32'd0);
        chk("t3_hold_value", 32'(value_o), 32'h0042);
        hold(4'b1011, P6, 4);
        idle(8);
        chk("t3_valid_cnt", 32'(vcount - v0), 32'd1);
        chk("t3_value", 32'(value_o), 32'h5678);
        chk("t3_blank", 32'(blank_o), 32'h0);

        // Invalid pattern in digit 1
        v0 = vcount;
        scan4(P4, PBAD, P2, P1, 8);
        chk("t4a_valid_cnt", 32'(vcount - v0), 32'd1);
        chk("t4a_value", 32'(value_o), 32'h1204);
        chk("t4a_blank", 32'(blank_o), 32'h0);
        chk("t4a_err",   32'(err_o),   32'h1);

        // Multi-anode sample taints the next frame
        v0 = vcount;
        hold(4'b1100, P0, 8);
        scan4(PC, P0, P9, PD, 8);
        chk("t4b_valid_cnt", 32'(vcount - v0), 32'd1);
        chk("t4b_value", 32'(value_o), 32'hD90C);
        chk("t4b_err",   32'(err_o),   32'h1);

        // Timeout drops a partial frame
        v0 = vcount;
        hold(4'b1011, PE, 8);
        hold(4'b0111, PB, 8);
        idle(60);
        chk("t5_stale", 32'(stale_o), 32'h1);
        chk("t5_no_valid", 32'(vcount - v0), 32'd0);
        chk("t5_hold_value", 32'(value_o), 32'hD90C);
        hold(4'b1110, PF, 8);
        hold(4'b1101, PE, 8);
        idle(8);
        chk("t5_partial_dropped", 32'(vcount - v0), 32'd0);
        scan4(PF, PE, PE, PB, 8);
        chk("t5_valid_cnt", 32'(vcount - v0), 32'd1);
        chk("t5_value", 32'(value_o), 32'hBEEF);
        chk("t5_stale_clr", 32'(stale_o), 32'h0);
        chk("t5_err", 32'(err_o), 32'h0);

        // Reset mid-frame
        hold(4'b1110, P0, 8);
        hold(4'b1101, P1, 8);
        hold(4'b1011, P2, 8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_value", 32'(value_o), 32'h0);
        chk("t6_rst_valid", 32'(valid_o), 32'h0);
        chk("t6_rst_err",   32'(err_o),   32'h0);
        chk("t6_rst_blank", 32'(blank_o), 32'h0);
        chk("t6_rst_stale", 32'(stale_o), 32'h1);
        idle(3);
        rst_n = 1'b1;
        idle(5);
        v0 = vcount;
        hold(4'b0111, P3, 8);
        idle(8);
        chk("t6_single_no_valid", 32'(vcount - v0), 32'd0);
        chk("t6_still_stale", 32'(stale_o), 32'h1);
        scan4(P0, P1, P2, P3, 8);
        chk("t6_valid_cnt", 32'(vcount - v0), 32'd1);
        chk("t6_value", 32'(value_o), 32'h3210);
        chk("t6_stale_clr", 32'(stale_o), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
